// File: rtl/sata_prims.sv
// SATA primitive words as seen on the 16-bit encoder interface (byte [7:0] goes out first),
// plus the transmit scheduler state encoding.
package sata_prims;

  localparam logic [15:0] ALIGN_LO_DATA = 16'h4ABC;  // K28.5 D10.2
  localparam logic [1:0]  ALIGN_LO_ISK  = 2'b01;
  localparam logic [15:0] ALIGN_HI_DATA = 16'h7B4A;  // D10.2 D27.3
  localparam logic [1:0]  ALIGN_HI_ISK  = 2'b00;

  localparam logic [15:0] SYNC_LO_DATA  = 16'h957C;  // K28.3 D21.4
  localparam logic [1:0]  SYNC_LO_ISK   = 2'b01;
  localparam logic [15:0] SYNC_HI_DATA  = 16'hB5B5;  // D21.5 D21.5
  localparam logic [1:0]  SYNC_HI_ISK   = 2'b00;

  typedef enum logic [2:0] {
    ST_DATA_LO = 3'd0,
    ST_DATA_HI = 3'd1,
    ST_FILL_HI = 3'd2,
    ST_ALN_LO  = 3'd3,
    ST_ALN_HI  = 3'd4
  } tx_state_t;

endpackage

// File: rtl/gtx_tx_align_sched.sv
// Dword transmit scheduler: merges link words with periodic ALIGN bursts and SYNC filler
// ahead of the 8b/10b encoder. Everything toward the encoder is registered.
module gtx_tx_align_sched
  import sata_prims::*;
#(
  parameter int ALIGN_PERIOD = 254,
  parameter int ALIGN_BURST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        align_en,
  input  logic        align_force,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_isk,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_isk,
  output logic        out_align,
  output logic        underrun
);

  localparam logic [7:0] PERIOD_LAST = 8'(ALIGN_PERIOD - 1);
  localparam logic [2:0] BURST_LEN   = 3'(ALIGN_BURST);

  tx_state_t   state_reg, state_next;
  logic [7:0]  period_reg, period_next;
  logic [2:0]  burst_reg, burst_next;
  logic [2:0]  burst_inc;
  logic [15:0] data_reg, data_next;
  logic [1:0]  isk_reg, isk_next;
  logic        align_reg, align_next;
  logic        underrun_reg, underrun_next;
  logic        complete;
  logic        aln_dword;

  assign in_ready  = (state_reg == ST_DATA_LO) || (state_reg == ST_DATA_HI);
  assign out_data  = data_reg;
  assign out_isk   = isk_reg;
  assign out_align = align_reg;
  assign underrun  = underrun_reg;
  assign burst_inc = burst_reg + 3'd1;

  always_comb begin
    state_next    = state_reg;
    period_next   = period_reg;
    burst_next    = burst_reg;
    data_next     = SYNC_LO_DATA;
    isk_next      = SYNC_LO_ISK;
    align_next    = 1'b0;
    underrun_next = 1'b0;
    complete      = 1'b0;
    aln_dword     = 1'b0;

    case (state_reg)
      ST_DATA_LO: begin
        if (in_valid) begin
          data_next  = in_data;
          isk_next   = in_isk;
          state_next = ST_DATA_HI;
        end else begin
          state_next = ST_FILL_HI;
        end
      end
      ST_DATA_HI: begin
        if (in_valid) begin
          data_next = in_data;
          isk_next  = in_isk;
        end else begin
          // The LO half already went out; close the dword with SYNC's HI half.
          data_next     = SYNC_HI_DATA;
          isk_next      = SYNC_HI_ISK;
          underrun_next = 1'b1;
        end
        complete = 1'b1;
      end
      ST_FILL_HI: begin
        data_next = SYNC_HI_DATA;
        isk_next  = SYNC_HI_ISK;
        complete  = 1'b1;
      end
      ST_ALN_LO: begin
        data_next  = ALIGN_LO_DATA;
        isk_next   = ALIGN_LO_ISK;
        align_next = 1'b1;
        state_next = ST_ALN_HI;
      end
      ST_ALN_HI: begin
        data_next  = ALIGN_HI_DATA;
        isk_next   = ALIGN_HI_ISK;
        align_next = 1'b1;
        burst_next = burst_inc;
        aln_dword  = 1'b1;
        complete   = 1'b1;
      end
      default: begin
        state_next = ST_ALN_LO;
      end
    endcase

    if (complete) begin
      if (align_force) begin
        // Clearing the burst count here guarantees a full burst after force drops.
        state_next  = ST_ALN_LO;
        period_next = 8'd0;
        burst_next  = 3'd0;
      end else if (aln_dword && (burst_inc < BURST_LEN)) begin
        state_next = ST_ALN_LO;
      end else if (aln_dword) begin
        state_next  = ST_DATA_LO;
        period_next = 8'd0;
      end else if (align_en && (period_reg == PERIOD_LAST)) begin
        state_next  = ST_ALN_LO;
        period_next = 8'd0;
        burst_next  = 3'd0;
      end else begin
        state_next  = ST_DATA_LO;
        period_next = align_en ? (period_reg + 8'd1) : 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_ALN_LO;
      period_reg   <= 8'd0;
      burst_reg    <= 3'd0;
      data_reg     <= SYNC_LO_DATA;
      isk_reg      <= SYNC_LO_ISK;
      align_reg    <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      period_reg   <= period_next;
      burst_reg    <= burst_next;
      data_reg     <= data_next;
      isk_reg      <= isk_next;
      align_reg    <= align_next;
      underrun_reg <= underrun_next;
    end
  end

endmodule

// File: tb/tb_gtx_tx_align_sched.sv
// Bench for gtx_tx_align_sched: a dword-level reference model checked every cycle,
// plus directed literal checks for reset, burst spacing, underrun and align_en off.
module tb_gtx_tx_align_sched;

  localparam int P = 4;
  localparam int B = 2;

  localparam int K_ALIGN = 0;
  localparam int K_OPEN  = 1;
  localparam int K_DATA  = 2;
  localparam int K_FILL  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        align_en = 1'b1;
  logic        align_force = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic [1:0]  in_isk = 2'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_isk;
  logic        out_align;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  gtx_tx_align_sched #(.ALIGN_PERIOD(P), .ALIGN_BURST(B)) dut (
    .clk(clk), .rst(rst), .align_en(align_en), .align_force(align_force),
    .in_data(in_data), .in_isk(in_isk), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_isk(out_isk), .out_align(out_align), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reference model: what kind of dword is on the wire and how many ALIGNs are still owed.
  int          m_phase = 0;
  int          m_kind  = K_ALIGN;
  int          m_rem   = B;
  int          m_cnt   = 0;
  logic [15:0] e_data  = 16'h957C;
  logic [1:0]  e_isk   = 2'b01;
  logic        e_align = 1'b0;
  logic        e_under = 1'b0;
  bit          started = 0;

  always @(posedge clk) begin
    started = 1;
    e_align = 1'b0;
    e_under = 1'b0;
    if (!rst) begin
      m_phase = 0; m_kind = K_ALIGN; m_rem = B; m_cnt = 0;
      e_data = 16'h957C; e_isk = 2'b01;
    end else if (m_phase == 0) begin
      if (m_kind == K_ALIGN) begin
        e_data = 16'h4ABC; e_isk = 2'b01; e_align = 1'b1;
      end else if (in_valid) begin
        e_data = in_data; e_isk = in_isk; m_kind = K_DATA;
      end else begin
        e_data = 16'h957C; e_isk = 2'b01; m_kind = K_FILL;
      end
      m_phase = 1;
    end else begin
      bit was_align;
      was_align = (m_kind == K_ALIGN);
      if (was_align) begin
        e_data = 16'h7B4A; e_isk = 2'b00; e_align = 1'b1;
        m_rem = m_rem - 1;
      end else if (m_kind == K_DATA && in_valid) begin
        e_data = in_data; e_isk = in_isk;
      end else begin
        e_data = 16'hB5B5; e_isk = 2'b00;
        e_under = (m_kind == K_DATA);
      end
      if (align_force) begin
        m_rem = B; m_cnt = 0;
      end else if (was_align) begin
        if (m_rem == 0) m_cnt = 0;
      end else if (align_en) begin
        if (m_cnt == P - 1) begin
          m_rem = B; m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        m_cnt = 0;
      end
      m_kind  = (m_rem > 0) ? K_ALIGN : K_OPEN;
      m_phase = 0;
    end
  end

  int prints = 0;
  task automatic report(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (prints < 30) begin
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        prints++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      report("model_data", 32'(out_data), 32'(e_data));
      report("model_isk", 32'(out_isk), 32'(e_isk));
      report("model_align", 32'(out_align), 32'(e_align));
      report("model_underrun", 32'(underrun), 32'(e_under));
      report("model_ready", 32'(in_ready), 32'((m_kind == K_OPEN) || (m_kind == K_DATA)));
    end
  end

  // Advance to 1 time unit after the next rising edge and refresh the link word.
  task automatic tick();
    @(posedge clk);
    #1;
    in_data = 16'($urandom);
    in_isk  = 2'($urandom);
  endtask

  logic [15:0] lit_data [0:5];
  logic [1:0]  lit_isk  [0:5];
  logic        lit_aln  [0:5];

  initial begin
    int aln_run, dat_run, rdy_run, last_aln, last_dat, last_rdy, seen_aln, aln_words;
    bit found;
    lit_data[0] = 16'h4ABC; lit_isk[0] = 2'b01; lit_aln[0] = 1'b1;
    lit_data[1] = 16'h7B4A; lit_isk[1] = 2'b00; lit_aln[1] = 1'b1;
    lit_data[2] = 16'h4ABC; lit_isk[2] = 2'b01; lit_aln[2] = 1'b1;
    lit_data[3] = 16'h7B4A; lit_isk[3] = 2'b00; lit_aln[3] = 1'b1;
    lit_data[4] = 16'h957C; lit_isk[4] = 2'b01; lit_aln[4] = 1'b0;
    lit_data[5] = 16'hB5B5; lit_isk[5] = 2'b00; lit_aln[5] = 1'b0;

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) tick();
    #1;
    report("reset_data", 32'(out_data), 32'h957C);
    report("reset_isk", 32'(out_isk), 32'h1);
    report("reset_ready", 32'(in_ready), 32'h0);
    $display("reset: out=%h/%b ready=%b", out_data, out_isk, in_ready);

    @(posedge clk); #1 rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      report("release_data", 32'(out_data), 32'(lit_data[k]));
      report("release_isk", 32'(out_isk), 32'(lit_isk[k]));
      report("release_align", 32'(out_align), 32'(lit_aln[k]));
      $display("release word %0d: out=%h/%b align=%b", k, out_data, out_isk, out_align);
    end

    // Continuous data: measure run lengths between and of ALIGN bursts.
    in_valid = 1'b1;
    aln_run = 0; dat_run = 0; rdy_run = 0;
    last_aln = -1; last_dat = -1; last_rdy = -1; seen_aln = 0;
    for (int i = 0; i < 80; i++) begin
      tick(); #1;
      if (out_align) begin
        if (aln_run == 0 && seen_aln != 0) last_dat = dat_run;
        aln_run++; dat_run = 0; seen_aln = 1;
      end else begin
        if (aln_run != 0) last_aln = aln_run;
        aln_run = 0; dat_run++;
      end
      if (!in_ready) rdy_run++;
      else begin
        if (rdy_run != 0) last_rdy = rdy_run;
        rdy_run = 0;
      end
    end
    report("burst_len", 32'(last_aln), 32'd4);
    report("data_between_bursts", 32'(last_dat), 32'd8);
    report("ready_low_len", 32'(last_rdy), 32'd4);
    $display("period: align_run=%0d data_run=%0d ready_low=%0d", last_aln, last_dat, last_rdy);

    // Directed underrun: drop valid in a data HI cycle.
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (m_phase == 1 && m_kind == K_DATA) begin
        in_valid = 1'b0;
        found = 1;
      end
    end
    report("underrun_setup_found", 32'(found), 32'h1);
    @(posedge clk); #2;
    report("underrun_pulse", 32'(underrun), 32'h1);
    report("underrun_data", 32'(out_data), 32'hB5B5);
    $display("underrun: out=%h underrun=%b", out_data, underrun);
    in_valid = 1'b1;
    @(posedge clk); #2;
    report("underrun_one_cycle", 32'(underrun), 32'h0);

    // Randomised traffic with occasional force and a mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      tick();
      in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) align_force = ~align_force;
      if (i == 1500) rst = 1'b0;
      if (i == 1502) rst = 1'b1;
    end
    align_force = 1'b0;
    $display("random phase done: checks=%0d", checks);

    // align_en low for 600 dwords.
    align_en = 1'b0;
    aln_words = 0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      in_valid = $urandom_range(0, 1);
      #1;
      if (i >= 12 && out_align) aln_words++;
    end
    report("no_align_when_disabled", 32'(aln_words), 32'h0);
    $display("align_en off: align words=%0d", aln_words);

    align_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      in_valid = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 59) == 0) align_force = ~align_force;
    end
    align_force = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
